// File: rtl/sabana_stream_mux.sv
// Packet-granular round-robin mux of NUM_CH AXI4-Stream inputs into one FIFO-buffered output; 1-cycle accept-to-m_tvalid latency.
// s_tready is asserted only for the locked channel and only while the FIFO is not full; SABANA_STREAM_MUX_PKTCNT_EN enables pkt_count.
module sabana_stream_mux #(
    parameter int  DATA_W     = 128,
    parameter int  NUM_CH     = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tlast,
    output logic [CH_W-1:0]          m_tdest,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     busy,
    output logic [31:0]              pkt_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   next_grant;
    logic              found;

    logic [DATA_W-1:0] sel_data;
    logic              sel_vld;
    logic              sel_last;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_dest [FIFO_DEPTH];

    // Round-robin search: channels above last_grant first, then wrap to the low indices.
    always_comb begin
        next_grant = last_grant;
        found      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && s_tvalid[i] && (i > int'(last_grant))) begin
                found      = 1'b1;
                next_grant = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && s_tvalid[i] && (i <= int'(last_grant))) begin
                found      = 1'b1;
                next_grant = CH_W'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_data = s_tdata[i*DATA_W +: DATA_W];
                sel_vld  = s_tvalid[i];
                sel_last = s_tlast[i];
            end
        end
    end

    // Ready uses the registered full flag only, so a same-cycle pop never opens the input.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state == ST_LOCKED) && !full && (grant == CH_W'(i))) begin
                s_tready[i] = 1'b1;
            end
        end
    end

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = (state == ST_LOCKED) && !full && sel_vld;
    assign pop   = !empty && m_tready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= ST_LOCKED;
                    end
                end
                default: begin
                    if (push && sel_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= sel_data;
            mem_last[wr_ptr] <= sel_last;
            mem_dest[wr_ptr] <= grant;
        end
    end

    // Storage is not reset; outputs are forced to zero while empty to give defined reset values.
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0   : mem_data[rd_ptr];
    assign m_tlast  = empty ? 1'b0 : mem_last[rd_ptr];
    assign m_tdest  = empty ? '0   : mem_dest[rd_ptr];
    assign busy     = (state == ST_LOCKED) || !empty;

`ifdef SABANA_STREAM_MUX_PKTCNT_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (pop && m_tlast) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = 32'd0;
`endif

endmodule

// File: tb/tb_sabana_stream_mux.sv
// Directed bench for sabana_stream_mux: a 2-channel/128-bit instance and a 3-channel/8-bit instance for wrap-around arbitration.
module tb_sabana_stream_mux;
    localparam int DW = 128;
    localparam int NC = 2;
`ifdef SABANA_STREAM_MUX_PKTCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC*DW-1:0] s_tdata;
    logic [NC-1:0]    s_tvalid;
    logic [NC-1:0]    s_tlast;
    logic [NC-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast;
    logic [0:0]       m_tdest;
    logic             m_tvalid;
    logic             m_tready;
    logic             busy;
    logic [31:0]      pkt_count;

    sabana_stream_mux #(.DATA_W(DW), .NUM_CH(NC), .FIFO_DEPTH(4)) dut (
        .clock(clk), .reset(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tdest(m_tdest), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .busy(busy), .pkt_count(pkt_count)
    );

    logic [23:0] c3_sdata;
    logic [2:0]  c3_svalid;
    logic [2:0]  c3_slast;
    logic [2:0]  c3_sready;
    logic [7:0]  c3_mdata;
    logic        c3_mlast;
    logic [1:0]  c3_mdest;
    logic        c3_mvalid;
    logic        c3_mready;
    logic        c3_busy;
    logic [31:0] c3_pkt;

    sabana_stream_mux #(.DATA_W(8), .NUM_CH(3), .FIFO_DEPTH(2)) dut3 (
        .clock(clk), .reset(rst),
        .s_tdata(c3_sdata), .s_tvalid(c3_svalid), .s_tlast(c3_slast), .s_tready(c3_sready),
        .m_tdata(c3_mdata), .m_tlast(c3_mlast), .m_tdest(c3_mdest), .m_tvalid(c3_mvalid),
        .m_tready(c3_mready), .busy(c3_busy), .pkt_count(c3_pkt)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    logic          got_t [$];
    int            c3_dst [$];
    logic [7:0]    c3_dat [$];

    int ed [$];
    bit el [$];

    // Source model state: per channel packet length, packets to send, progress and an optional gap.
    int   plen [NC];
    int   npkt [NC];
    int   pk [NC];
    int   bt [NC];
    int   gap_at [NC];
    int   gap_left [NC];
    logic intrude;

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
            got_t.push_back(m_tdest[0]);
        end
        if (!rst && c3_mvalid && c3_mready) begin
            c3_dst.push_back(int'(c3_mdest));
            c3_dat.push_back(c3_mdata);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < NC; ch++) begin
            plen[ch]     = 1;
            npkt[ch]     = 0;
            pk[ch]       = 0;
            bt[ch]       = 0;
            gap_at[ch]   = -1;
            gap_left[ch] = 0;
        end
        intrude = 1'b0;
        got_d.delete();
        got_l.delete();
        got_t.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        m_tready  = 1'b1;
        c3_sdata  = '0;
        c3_svalid = '0;
        c3_slast  = '0;
        c3_mready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step();
        logic [NC-1:0] acc;
        for (int ch = 0; ch < NC; ch++) begin
            s_tvalid[ch] = (pk[ch] < npkt[ch]) && !((bt[ch] == gap_at[ch]) && (gap_left[ch] > 0));
            s_tlast[ch]  = (bt[ch] == plen[ch] - 1);
            s_tdata[ch*DW +: DW] = DW'(ch*256 + pk[ch]*16 + bt[ch] + 1);
        end
        @(negedge clk);
        acc = s_tvalid & s_tready;
        if ((pk[0] < npkt[0]) && s_tready[1]) intrude = 1'b1;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NC; ch++) begin
            if (acc[ch]) begin
                if (bt[ch] == plen[ch] - 1) begin
                    bt[ch] = 0;
                    pk[ch]++;
                end else begin
                    bt[ch]++;
                end
            end else if (!s_tvalid[ch] && (gap_left[ch] > 0) && (bt[ch] == gap_at[ch])) begin
                gap_left[ch]--;
            end
        end
    endtask

    task automatic run(input int budget, input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = 1'b1;
            for (int ch = 0; ch < NC; ch++) if (pk[ch] < npkt[ch]) done = 1'b0;
            if (m_tvalid || busy) done = 1'b0;
        end
        chk(tag, 128'(done), 128'(1));
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_n"}, 128'(got_d.size()), 128'(ed.size()));
        for (int i = 0; i < ed.size(); i++) begin
            if (i < got_d.size()) begin
                chk($sformatf("%s_d%0d", tag, i), got_d[i], 128'(ed[i]));
                chk($sformatf("%s_t%0d", tag, i), 128'(got_t[i]), 128'(ed[i] >= 256));
                chk($sformatf("%s_l%0d", tag, i), 128'(got_l[i]), 128'(el[i]));
            end
        end
    endtask

    initial begin
        // Reset values while reset is held.
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        m_tready  = 1'b1;
        c3_sdata  = '0;
        c3_svalid = '0;
        c3_slast  = '0;
        c3_mready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tlast", 128'(m_tlast), 128'(0));
        chk("rst_m_tdest", 128'(m_tdest), 128'(0));
        chk("rst_m_tdata", m_tdata, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_c3_sready", 128'(c3_sready), 128'(0));
        rst = 1'b0;

        // Single 3-beat packet on ch0, cycle-exact.
        npkt[0] = 1;
        plen[0] = 3;
        step();
        chk("sp_grant_ready", 128'(s_tready), 128'(2'b01));
        chk("sp_no_out_yet", 128'(m_tvalid), 128'(0));
        chk("sp_busy_locked", 128'(busy), 128'(1));
        step();
        chk("sp_lat_valid", 128'(m_tvalid), 128'(1));
        chk("sp_b0_data", m_tdata, 128'(1));
        chk("sp_b0_dest", 128'(m_tdest), 128'(0));
        chk("sp_b0_last", 128'(m_tlast), 128'(0));
        step();
        chk("sp_b1_data", m_tdata, 128'(2));
        chk("sp_b1_last", 128'(m_tlast), 128'(0));
        step();
        chk("sp_b2_data", m_tdata, 128'(3));
        chk("sp_b2_last", 128'(m_tlast), 128'(1));
        chk("sp_idle_ready", 128'(s_tready), 128'(0));
        chk("sp_busy_fifo", 128'(busy), 128'(1));
        step();
        chk("sp_drained", 128'(m_tvalid), 128'(0));
        chk("sp_busy_low", 128'(busy), 128'(0));
        chk("sp_pkt_count", 128'(pkt_count), 128'(CNT_EN));
        ed = {1, 2, 3};
        el = {1'b0, 1'b0, 1'b1};
        chk_seq("sp");

        // Round-robin between two always-valid channels with 2-beat packets.
        do_reset();
        npkt[0] = 2; plen[0] = 2;
        npkt[1] = 2; plen[1] = 2;
        run(60, "rr_done");
        ed = {'h001, 'h002, 'h101, 'h102, 'h011, 'h012, 'h111, 'h112};
        el = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        chk_seq("rr");
        chk("rr_pkt_count", 128'(pkt_count), 128'(4 * CNT_EN));

        // ch0 pauses 5 cycles mid-packet; ch1 must wait for ch0's tlast.
        do_reset();
        npkt[0] = 1; plen[0] = 4; gap_at[0] = 2; gap_left[0] = 5;
        npkt[1] = 1; plen[1] = 2;
        run(80, "gap_done");
        chk("gap_taken", 128'(gap_left[0]), 128'(0));
        chk("gap_no_intrude", 128'(intrude), 128'(0));
        ed = {'h001, 'h002, 'h003, 'h004, 'h101, 'h102};
        el = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        chk_seq("gap");

        // Backpressure: 6-beat packet into a 4-entry FIFO with m_tready low.
        do_reset();
        m_tready = 1'b0;
        npkt[1] = 1; plen[1] = 6;
        repeat (6) step();
        chk("bp_accepted", 128'(bt[1]), 128'(4));
        chk("bp_ready_low", 128'(s_tready), 128'(0));
        chk("bp_valid", 128'(m_tvalid), 128'(1));
        chk("bp_head", m_tdata, 128'('h101));
        repeat (3) step();
        chk("bp_head_stable", m_tdata, 128'('h101));
        chk("bp_still_blocked", 128'(bt[1]), 128'(4));
        chk("bp_busy", 128'(busy), 128'(1));
        m_tready = 1'b1;
        run(40, "bp_done");
        ed = {'h101, 'h102, 'h103, 'h104, 'h105, 'h106};
        el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        chk_seq("bp");
        chk("bp_pkt_count", 128'(pkt_count), 128'(CNT_EN));

        // Reset after 2 of 4 beats accepted; then a clean ch1 packet.
        do_reset();
        m_tready = 1'b0;
        npkt[0] = 1; plen[0] = 4;
        repeat (3) step();
        chk("mr_accepted", 128'(bt[0]), 128'(2));
        rst = 1'b1;
        #1;
        chk("mr_s_tready", 128'(s_tready), 128'(0));
        chk("mr_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("mr_m_tdata", m_tdata, 128'(0));
        chk("mr_m_tlast", 128'(m_tlast), 128'(0));
        chk("mr_busy", 128'(busy), 128'(0));
        chk("mr_pkt_count", 128'(pkt_count), 128'(0));
        @(posedge clk);
        #1;
        clear_model();
        s_tvalid = '0;
        m_tready = 1'b1;
        rst      = 1'b0;
        npkt[1] = 1; plen[1] = 3;
        run(40, "mr_done");
        ed = {'h101, 'h102, 'h103};
        el = {1'b0, 1'b0, 1'b1};
        chk_seq("mr");
        chk("mr_pkt_after", 128'(pkt_count), 128'(CNT_EN));

        // Three channels, all valid with 1-beat packets, from reset (last_grant=2).
        do_reset();
        c3_sdata  = {8'hA2, 8'hA1, 8'hA0};
        c3_slast  = 3'b111;
        c3_svalid = 3'b111;
        repeat (10) @(posedge clk);
        #1;
        c3_svalid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("wr_beats", 128'(c3_dst.size()), 128'(5));
        ed = {0, 1, 2, 0, 1};
        for (int i = 0; i < 5; i++) begin
            if (i < c3_dst.size()) begin
                chk($sformatf("wr_dest%0d", i), 128'(c3_dst[i]), 128'(ed[i]));
                chk($sformatf("wr_data%0d", i), 128'(c3_dat[i]), 128'('hA0 + ed[i]));
            end
        end
        chk("wr_pkt_count", 128'(c3_pkt), 128'(5 * CNT_EN));
`ifdef SABANA_STREAM_MUX_PKTCNT_EN
        force dut3.pkt_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut3.pkt_cnt_q;
        chk("wr_cnt_preload", 128'(c3_pkt), 128'(32'hFFFF_FFFF));
        c3_svalid = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        c3_svalid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("wr_cnt_wrap", 128'(c3_pkt), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
